stm_clkdiv_lfsr: RTL and testbench

Parametrised successor to the LED/clock-division state machine on the DE0 test board.
- Generates a 50%-duty divided clock for any integer divisor, odd or even.
- Steps an LFSR once per divided period and drives LEDs.
- A mode FSM cycles through divisor A, divisor B and a run-time divisor on each advance pulse.
- Produces a clock-enable (tick) for downstream logic instead of gating clocks.

---
 rtl/stm_clkdiv_lfsr_pkg.sv | 40 ++++
 rtl/stm_clkdiv_lfsr_if.sv | 28 ++
 rtl/stm_clkdiv_lfsr_lfsr_step.sv | 46 ++++
 rtl/stm_clkdiv_lfsr.sv | 179 +++++++++++++++++
 tb/tb_stm_clkdiv_lfsr.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/stm_clkdiv_lfsr_pkg.sv
// Shared constants for the clock-divider / LFSR LED block: FSM encodings,
// minimum divisor and default LFSR polynomial/seed.
package stm_clk_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_ALL_ON  = 3'd1,
    ST_RUN_A   = 3'd2,
    ST_RUN_B   = 3'd3,
    ST_RUN_EXT = 3'd4
  } state_e;

  localparam int         DIV_MIN       = 2;
  localparam logic [7:0] LFSR_TAPS_DEF = 8'hB8;
  localparam logic [7:0] LFSR_SEED_DEF = 8'h01;

  function automatic logic is_run(input state_e s);
    logic r;
    case (s)
      ST_RUN_A, ST_RUN_B, ST_RUN_EXT: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

  // RUN_EXT loops back to RUN_A; INIT/ALL_ON are only visited after reset.
  function automatic state_e next_state(input state_e s);
    state_e n;
    case (s)
      ST_INIT:    n = ST_ALL_ON;
      ST_ALL_ON:  n = ST_RUN_A;
      ST_RUN_A:   n = ST_RUN_B;
      ST_RUN_B:   n = ST_RUN_EXT;
      ST_RUN_EXT: n = ST_RUN_A;
      default:    n = ST_INIT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/stm_clkdiv_lfsr_if.sv
// Control/status bundle of stm_clkdiv_lfsr. The hold input exists only when
// STM_CLKDIV_HOLD_EN is defined.
interface stm_clkdiv_lfsr_if #(
  parameter int LED_W = 3,
  parameter int DIV_W = 8
);
  logic             advance;
  logic [DIV_W-1:0] div_ext;
`ifdef STM_CLKDIV_HOLD_EN
  logic             hold;
`endif
  logic             clk_div_out;
  logic             tick;
  logic [LED_W-1:0] led;
  logic [2:0]       state_out;

`ifdef STM_CLKDIV_HOLD_EN
  modport master (output advance, div_ext, hold,
                  input  clk_div_out, tick, led, state_out);
  modport slave  (input  advance, div_ext, hold,
                  output clk_div_out, tick, led, state_out);
`else
  modport master (output advance, div_ext,
                  input  clk_div_out, tick, led, state_out);
  modport slave  (input  advance, div_ext,
                  output clk_div_out, tick, led, state_out);
`endif
endinterface

// File: rtl/stm_clkdiv_lfsr_lfsr_step.sv
// Fibonacci LFSR that advances one step per enable; an all-zero value
// (lock-up) is replaced by the seed on the following edge.
module lfsr_step
  import stm_clk_pkg::*;
#(
  parameter int                LFSR_W    = 8,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(LFSR_TAPS_DEF),
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(LFSR_SEED_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [LFSR_W-1:0] prn
);

  logic [LFSR_W-1:0] prn_r;
  logic [LFSR_W-1:0] prn_next_s;

  function automatic logic parity(input logic [LFSR_W-1:0] v);
    return ^v;
  endfunction

  // Next value: lock-up recovery first, then shift-left with tapped feedback.
  always_comb begin
    prn_next_s = prn_r;
    if (prn_r == '0) begin
      prn_next_s = LFSR_SEED;
    end else if (en) begin
      prn_next_s = {prn_r[LFSR_W-2:0], parity(prn_r & LFSR_TAPS)};
    end else begin
      prn_next_s = prn_r;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prn_r <= LFSR_SEED;
    end else begin
      prn_r <= prn_next_s;
    end
  end

  assign prn = prn_r;

endmodule

// File: rtl/stm_clkdiv_lfsr.sv
// Mode FSM, odd/even 50% clock divider, tick enable and LFSR-driven LEDs.
// Optional freeze input enabled by defining STM_CLKDIV_HOLD_EN.
module stm_clkdiv_lfsr
  import stm_clk_pkg::*;
#(
  parameter int                LED_W     = 3,
  parameter int                DIV_W     = 8,
  parameter int                DIV_A     = 2,
  parameter int                DIV_B     = 3,
  parameter int                LFSR_W    = 8,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(LFSR_TAPS_DEF),
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(LFSR_SEED_DEF)
) (
  input  logic             clock_in,
  input  logic             reset,
  stm_clkdiv_lfsr_if.slave bus
);

  state_e            state_r;
  state_e            state_next_s;
  logic              run_s;
  logic              run_next_s;
  logic              state_chg_s;
  logic              hold_s;
  logic              tick_s;
  logic [DIV_W-1:0]  cnt_r;
  logic [DIV_W-1:0]  cnt_next_s;
  logic [DIV_W-1:0]  n_cur_r;
  logic [DIV_W-1:0]  n_next_s;
  logic [DIV_W-1:0]  div_sel_s;
  logic [DIV_W:0]    half_s;
  logic              p_r;
  logic              p_next_s;
  logic              p_neg_r;
  logic              clk_div_s;
  logic [LED_W-1:0]  led_r;
  logic [LED_W-1:0]  led_next_s;
  logic [LFSR_W-1:0] prn_s;

`ifdef STM_CLKDIV_HOLD_EN
  assign hold_s = bus.hold;
`else
  assign hold_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: one step around the mode ring per advance pulse.
  always_comb begin
    state_next_s = state_r;
    if (bus.advance) begin
      state_next_s = next_state(state_r);
    end else begin
      state_next_s = state_r;
    end
  end

  // FSM decoded outputs used by the datapath.
  always_comb begin
    run_s       = is_run(state_r);
    run_next_s  = is_run(state_next_s);
    state_chg_s = (state_next_s != state_r);
  end

  // Divisor is latched only on the edge entering a RUN state, clamped to >= 2.
  always_comb begin
    div_sel_s = n_cur_r;
    n_next_s  = n_cur_r;
    case (state_next_s)
      ST_RUN_A:   div_sel_s = DIV_W'(DIV_A);
      ST_RUN_B:   div_sel_s = DIV_W'(DIV_B);
      ST_RUN_EXT: div_sel_s = bus.div_ext;
      default:    div_sel_s = n_cur_r;
    endcase
    if (state_chg_s && run_next_s) begin
      n_next_s = (div_sel_s < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div_sel_s;
    end else begin
      n_next_s = n_cur_r;
    end
  end

  assign tick_s = run_s && !hold_s && (cnt_r == (n_cur_r - DIV_W'(1)));

  // Period counter: restarts on any mode change, frozen by hold otherwise.
  always_comb begin
    cnt_next_s = cnt_r;
    if (state_chg_s || !run_next_s) begin
      cnt_next_s = '0;
    end else if (hold_s) begin
      cnt_next_s = cnt_r;
    end else if (tick_s) begin
      cnt_next_s = '0;
    end else begin
      cnt_next_s = cnt_r + DIV_W'(1);
    end
  end

  // p is high for the first ceil(N/2) counts; widened so N=2^DIV_W-1 cannot wrap.
  always_comb begin
    half_s   = ({1'b0, n_next_s} + (DIV_W+1)'(1)) >> 1;
    p_next_s = p_r;
    if (hold_s && !state_chg_s) begin
      p_next_s = p_r;
    end else begin
      p_next_s = run_next_s && ({1'b0, cnt_next_s} < half_s);
    end
  end

  // LED source follows the state being entered so ALL_ON lights with state_out.
  always_comb begin
    led_next_s = led_r;
    case (state_next_s)
      ST_INIT:                        led_next_s = '0;
      ST_ALL_ON:                      led_next_s = '1;
      ST_RUN_A, ST_RUN_B, ST_RUN_EXT: led_next_s = prn_s[LED_W-1:0];
      default:                        led_next_s = '0;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      cnt_r   <= '0;
      n_cur_r <= DIV_W'(DIV_MIN);
      p_r     <= 1'b0;
      led_r   <= '0;
    end else begin
      cnt_r   <= cnt_next_s;
      n_cur_r <= n_next_s;
      p_r     <= p_next_s;
      led_r   <= led_next_s;
    end
  end

  // Half-cycle delayed copy of p; ANDed with p it trims odd periods to 50%.
  always_ff @(negedge clock_in or negedge reset) begin
    if (!reset) begin
      p_neg_r <= 1'b0;
    end else begin
      p_neg_r <= p_r;
    end
  end

  // Divided clock selection by divisor parity.
  always_comb begin
    clk_div_s = 1'b0;
    if (!run_s) begin
      clk_div_s = 1'b0;
    end else if (n_cur_r[0]) begin
      clk_div_s = p_r & p_neg_r;
    end else begin
      clk_div_s = p_r;
    end
  end

  lfsr_step #(
    .LFSR_W    (LFSR_W),
    .LFSR_TAPS (LFSR_TAPS),
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clock_in),
    .rst_n (reset),
    .en    (tick_s),
    .prn   (prn_s)
  );

  assign bus.tick        = tick_s;
  assign bus.led         = led_r;
  assign bus.state_out   = state_r;
  assign bus.clk_div_out = clk_div_s;

endmodule

// File: tb/tb_stm_clkdiv_lfsr.sv
// Directed bench for stm_clkdiv_lfsr with a cycle model feeding a scoreboard.
// Defining STM_CLKDIV_HOLD_EN also exercises the hold input.
module tb_stm_clkdiv_lfsr;

  logic clock_in = 1'b0;
  logic reset    = 1'b0;
  logic hold_v   = 1'b0;

  always #5 clock_in = ~clock_in;

  stm_clkdiv_lfsr_if #(.LED_W(3), .DIV_W(8)) bus ();

`ifdef STM_CLKDIV_HOLD_EN
  assign bus.hold = hold_v;
`endif

  stm_clkdiv_lfsr #(
    .LED_W(3), .DIV_W(8), .DIV_A(2), .DIV_B(3), .LFSR_W(8),
    .LFSR_TAPS(8'hB8), .LFSR_SEED(8'h01)
  ) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .bus      (bus)
  );

  typedef struct {
    logic [2:0] st;
    logic       tk;
    logic [2:0] led;
    logic       ck;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   obs_ticks = 0;
  int   obs_hi    = 0;

  // Reference model state, derived from the block description.
  int         m_state, m_cnt, m_n;
  logic [7:0] m_lfsr;
  logic       m_p, m_pn;
  logic [2:0] m_led;

  function automatic logic [7:0] lstep(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  function automatic int succ(input int s);
    case (s)
      0: return 1;
      1: return 2;
      2: return 3;
      3: return 4;
      4: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic bit mrun(input int s);
    return (s >= 2);
  endfunction

  function automatic logic mtick();
    return mrun(m_state) && !hold_v && (m_cnt == m_n - 1);
  endfunction

  function automatic logic mclk();
    if (!mrun(m_state)) return 1'b0;
    return (m_n % 2 == 1) ? (m_p & m_pn) : m_p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_n = 2; m_lfsr = 8'h01;
    m_p = 1'b0; m_pn = 1'b0; m_led = 3'b000;
  endtask

  task automatic model_edge();
    int ns, dv;
    bit chg;
    logic tk;
    logic [2:0] nl;
    if (!reset) begin
      model_reset();
      return;
    end
    tk  = mtick();
    ns  = bus.advance ? succ(m_state) : m_state;
    chg = (ns != m_state);
    nl  = (ns == 0) ? 3'b000 : (ns == 1) ? 3'b111 : m_lfsr[2:0];
    if (chg && mrun(ns)) begin
      dv = (ns == 2) ? 2 : (ns == 3) ? 3 : int'(bus.div_ext);
      if (dv < 2) dv = 2;
      m_n = dv;
    end
    if (chg || !mrun(ns)) m_cnt = 0;
    else if (hold_v) m_cnt = m_cnt;
    else if (tk) m_cnt = 0;
    else m_cnt = m_cnt + 1;
    if (m_lfsr == 8'h00) m_lfsr = 8'h01;
    else if (tk) m_lfsr = lstep(m_lfsr);
    if (!(hold_v && !chg)) m_p = mrun(ns) && (m_cnt < (m_n + 1) / 2);
    m_state = ns;
    m_led   = nl;
  endtask

  task automatic push_exp();
    exp_t e;
    e.st = 3'(m_state); e.tk = mtick(); e.led = m_led; e.ck = mclk();
    sb.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, "_state"}, 32'(bus.state_out), 32'(e.st));
    chk({tag, "_tick"},  32'(bus.tick),      32'(e.tk));
    chk({tag, "_led"},   32'(bus.led),       32'(e.led));
    chk({tag, "_clk"},   32'(bus.clk_div_out), 32'(e.ck));
  endtask

  // One clock: model update on each edge, DUT sampled 1 ns later.
  task automatic cyc();
    @(posedge clock_in);
    model_edge();
    push_exp();
    #1;
    pop_chk("pos");
    if (bus.tick === 1'b1) obs_ticks++;
    if (bus.clk_div_out === 1'b1) obs_hi++;
    @(negedge clock_in);
    m_pn = reset ? m_p : 1'b0;
    push_exp();
    #1;
    pop_chk("neg");
    if (bus.clk_div_out === 1'b1) obs_hi++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic adv();
    bus.advance = 1'b1;
    cyc();
    bus.advance = 1'b0;
  endtask

  task automatic clr_tally();
    obs_ticks = 0;
    obs_hi    = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] led_snap;
    bit found;
    bus.advance = 1'b0;
    bus.div_ext = 8'd0;
    model_reset();
    run(2);
    chk("rst_state", 32'(bus.state_out), 32'd0);
    chk("rst_led",   32'(bus.led),       32'd0);
    reset = 1'b1;
    run(3);

    adv();
    chk("all_on_led", 32'(bus.led), 32'h7);
    adv();
    chk("run_a_led_seed", 32'(bus.led), 32'h1);
    clr_tally();
    run(8);
    chk("run_a_ticks", 32'(obs_ticks), 32'd4);
    chk("run_a_high",  32'(obs_hi),    32'd8);

    adv();
    clr_tally();
    run(30);
    chk("run_b_ticks", 32'(obs_ticks), 32'd10);
    chk("run_b_high",  32'(obs_hi),    32'd30);
    run(1);

    // Asynchronous reset mid-period in RUN_B: outputs clear without a clock edge.
    reset = 1'b0;
    #1;
    chk("async_rst_state", 32'(bus.state_out),   32'd0);
    chk("async_rst_clk",   32'(bus.clk_div_out), 32'd0);
    chk("async_rst_led",   32'(bus.led),         32'd0);
    chk("async_rst_tick",  32'(bus.tick),        32'd0);
    model_reset();
    run(2);
    reset = 1'b1;
    run(1);
    adv();
    adv();
    chk("reseed_led", 32'(bus.led), 32'h1);
    run(3);

    bus.div_ext = 8'd0;
    adv();
    adv();
    clr_tally();
    run(6);
    chk("ext_clamp_ticks", 32'(obs_ticks), 32'd3);

    adv();
    adv();
    bus.div_ext = 8'd5;
    adv();
    clr_tally();
    run(10);
    chk("ext5_ticks", 32'(obs_ticks), 32'd2);
    chk("ext5_high",  32'(obs_hi),    32'd10);
    bus.div_ext = 8'd7;
    clr_tally();
    run(10);
    chk("ext5_hold_ticks", 32'(obs_ticks), 32'd2);
    chk("ext5_hold_high",  32'(obs_hi),    32'd10);

    adv();
    adv();
    adv();
    clr_tally();
    run(14);
    chk("ext7_ticks", 32'(obs_ticks), 32'd2);
    chk("ext7_high",  32'(obs_hi),    32'd14);

    // Advance coinciding with a tick.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus.tick === 1'b1) found = 1'b1;
      else cyc();
    end
    chk("tick_found", 32'(bus.tick), 32'd1);
    adv();
    chk("adv_tick_state",  32'(bus.state_out), 32'd2);
    chk("adv_tick_notick", 32'(bus.tick),      32'd0);
    run(5);

`ifdef STM_CLKDIV_HOLD_EN
    led_snap = bus.led;
    hold_v = 1'b1;
    clr_tally();
    run(7);
    chk("hold_ticks", 32'(obs_ticks), 32'd0);
    chk("hold_led",   32'(bus.led),   32'(led_snap));
    hold_v = 1'b0;
    run(4);
`else
    led_snap = bus.led;
    run(2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
